alu_exec: RTL and testbench

Execute-stage ALU that consumes the 14-bit one-hot `aluop` bus produced by the instruction decoder and performs the operation on two 32-bit operands. Sits between register read and writeback/PC-select. Single-cycle ops: registered result one cycle after acceptance. MUL/MULH: iterative radix-2 Booth multiplier with a valid/ready handshake that stalls the front end while busy.

---
 rtl/alu_exec.sv | 172 +++++++++++++++++
 tb/tb_alu_exec.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Execute-stage ALU: one-hot aluop decode, single-cycle ops,
// and an iterative radix-2 Booth multiplier for MUL/MULH.
module alu_exec #(
    parameter int XLEN      = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic            clock,
    input  logic            nreset,
    input  logic [13:0]     aluop,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            branch_taken
);

    localparam int CW = $clog2(MUL_STEPS);

    typedef enum logic {IDLE, MULT} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   acc_q, acc_d;
    logic [XLEN-1:0] mpl_q, mpl_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic            qm1_q, qm1_d;
    logic            mulh_q, mulh_d;
    logic            bpend_q, bpend_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            br_q, br_d;

    logic            accept;
    logic [XLEN-1:0] res_alu;
    logic            is_mul, is_mulh, br;
    logic [XLEN:0]   mc_ext, sum, acc_n;
    logic [XLEN-1:0] mpl_n;
    logic [2*XLEN-1:0] prod;

    assign in_ready     = (state_q == IDLE);
    assign accept       = in_valid & in_ready;
    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign branch_taken = br_q;

    // Arithmetic group; RBUS0 suppresses the group entirely
    always_comb begin
        res_alu = '0;
        is_mul  = 1'b0;
        is_mulh = 1'b0;
        if (!aluop[5]) begin
            priority case (1'b1)
                aluop[13]: res_alu = a + b;
                aluop[12]: res_alu = a << b[4:0];
                aluop[11]: res_alu = $signed(a) >>> b[4:0];
                aluop[10]: res_alu = a ^ b;
                aluop[9]:  res_alu = a & b;
                aluop[8]:  res_alu = a | b;
                aluop[7]:  is_mul  = 1'b1;
                aluop[6]: begin
                    is_mul  = 1'b1;
                    is_mulh = 1'b1;
                end
                default:   res_alu = '0;
            endcase
        end
    end

    always_comb begin
        br = 1'b0;
        if (!aluop[0]) begin
            priority case (1'b1)
                aluop[4]: br = (a == b);
                aluop[3]: br = (a != b);
                aluop[2]: br = ($signed(a) < $signed(b));
                aluop[1]: br = ($signed(a) >= $signed(b));
                default:  br = 1'b0;
            endcase
        end
    end

    // One Booth step: add/sub multiplicand, then arithmetic shift right
    always_comb begin
        mc_ext = {mcand_q[XLEN-1], mcand_q};
        case ({mpl_q[0], qm1_q})
            2'b01:   sum = acc_q + mc_ext;
            2'b10:   sum = acc_q - mc_ext;
            default: sum = acc_q;
        endcase
        acc_n = {sum[XLEN], sum[XLEN:1]};
        mpl_n = {sum[0], mpl_q[XLEN-1:1]};
        prod  = {acc_n[XLEN-1:0], mpl_n};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mpl_d       = mpl_q;
        mcand_d     = mcand_q;
        qm1_d       = qm1_q;
        mulh_d      = mulh_q;
        bpend_d     = bpend_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        br_d        = br_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) begin
                    state_d = MULT;
                    mcand_d = a;
                    mpl_d   = b;
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CW'(MUL_STEPS - 1);
                    mulh_d  = is_mulh;
                    bpend_d = br;
                end else if (accept) begin
                    result_d    = res_alu;
                    br_d        = br;
                    out_valid_d = 1'b1;
                end
            end
            MULT: begin
                acc_d = acc_n;
                mpl_d = mpl_n;
                qm1_d = mpl_q[0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    result_d    = mulh_q ? prod[2*XLEN-1:XLEN]
                                         : prod[XLEN-1:0];
                    br_d        = bpend_q;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mpl_q       <= '0;
            mcand_q     <= '0;
            qm1_q       <= 1'b0;
            mulh_q      <= 1'b0;
            bpend_q     <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            br_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mpl_q       <= mpl_d;
            mcand_q     <= mcand_d;
            qm1_q       <= qm1_d;
            mulh_q      <= mulh_d;
            bpend_q     <= bpend_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            br_q        <= br_d;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alu_exec;

    localparam logic [13:0] ADD   = 14'h2000;
    localparam logic [13:0] SLL   = 14'h1000;
    localparam logic [13:0] SRA   = 14'h0800;
    localparam logic [13:0] XOR   = 14'h0400;
    localparam logic [13:0] MUL   = 14'h0080;
    localparam logic [13:0] MULH  = 14'h0040;
    localparam logic [13:0] RBUS0 = 14'h0020;
    localparam logic [13:0] EQ    = 14'h0010;
    localparam logic [13:0] LT    = 14'h0004;
    localparam logic [13:0] GE    = 14'h0002;
    localparam logic [13:0] BBUS0 = 14'h0001;

    logic        clock = 1'b0;
    logic        nreset;
    logic [13:0] aluop;
    logic [31:0] a, b;
    logic        in_valid;
    logic        in_ready, out_valid, branch_taken;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    alu_exec dut (
        .clock       (clock),
        .nreset      (nreset),
        .aluop       (aluop),
        .a           (a),
        .b           (b),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .result      (result),
        .branch_taken(branch_taken)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [13:0] op, input logic [31:0] x,
                         input logic [31:0] y);
        aluop    = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
    endtask

    task automatic single(input string tag, input logic [13:0] op,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic eb);
        drive(op, x, y);
        step();
        in_valid = 1'b0;
        chk({tag, "_ov"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_res"}, result, er);
        chk({tag, "_br"}, {31'b0, branch_taken}, {31'b0, eb});
    endtask

    task automatic mul_run(input string tag, input logic [13:0] op,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] er);
        int busy;
        drive(op, x, y);
        step();
        in_valid = 1'b0;
        busy = 0;
        for (int i = 0; i < 32; i++) begin
            if (!in_ready && !out_valid) busy++;
            step();
        end
        chk({tag, "_busy"}, busy, 32'd32);
        chk({tag, "_ov"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_res"}, result, er);
    endtask

    initial begin
        int busy, spur;
        nreset   = 1'b0;
        in_valid = 1'b0;
        aluop    = '0;
        a        = '0;
        b        = '0;
        step();
        step();
        chk("rst_rdy", {31'b0, in_ready}, 32'd1);
        chk("rst_ov", {31'b0, out_valid}, 32'd0);
        chk("rst_res", result, 32'h0);
        chk("rst_br", {31'b0, branch_taken}, 32'd0);
        nreset = 1'b1;

        // Back-to-back ADD then SRA
        drive(ADD | BBUS0, 32'h7FFFFFFF, 32'h1);
        step();
        chk("b2b_add_ov", {31'b0, out_valid}, 32'd1);
        chk("b2b_add_res", result, 32'h80000000);
        chk("b2b_add_rdy", {31'b0, in_ready}, 32'd1);
        drive(SRA | BBUS0, 32'h80000000, 32'h24);
        step();
        in_valid = 1'b0;
        chk("b2b_sra_ov", {31'b0, out_valid}, 32'd1);
        chk("b2b_sra_res", result, 32'hF8000000);
        step();
        chk("idle_ov", {31'b0, out_valid}, 32'd0);
        chk("hold_res", result, 32'hF8000000);

        single("sll", SLL | BBUS0, 32'h00000003, 32'hFFFFFFE4, 32'h30, 1'b0);
        single("xor", XOR | BBUS0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00,
               1'b0);
        single("prio", ADD | XOR | BBUS0, 32'h5, 32'h3, 32'h8, 1'b0);
        single("noop", BBUS0, 32'h5, 32'h3, 32'h0, 1'b0);

        mul_run("mul_neg", MUL | BBUS0, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB);
        mul_run("mulh_min", MULH | BBUS0, 32'h80000000, 32'h80000000,
                32'h40000000);
        mul_run("mulh_m1", MULH | BBUS0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);

        single("lt", RBUS0 | LT, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1);
        single("ge", RBUS0 | GE, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
        single("eq", RBUS0 | EQ, 32'h1234, 32'h1234, 32'h0, 1'b1);
        single("bbus0", ADD | EQ | BBUS0, 32'h1234, 32'h1234, 32'h2468, 1'b0);

        // ADD held valid while the multiplier is busy
        drive(MUL | BBUS0, 32'h2, 32'h3);
        step();
        drive(ADD | BBUS0, 32'h1, 32'h1);
        busy = 0;
        for (int i = 0; i < 32; i++) begin
            if (!in_ready && !out_valid) busy++;
            step();
        end
        chk("stall_busy", busy, 32'd32);
        chk("stall_mul_ov", {31'b0, out_valid}, 32'd1);
        chk("stall_mul_res", result, 32'h6);
        step();
        in_valid = 1'b0;
        chk("stall_add_ov", {31'b0, out_valid}, 32'd1);
        chk("stall_add_res", result, 32'h2);

        // Reset during a multiply
        drive(MUL | BBUS0, 32'h5, 32'h9);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        nreset = 1'b0;
        step();
        nreset = 1'b1;
        chk("abort_rdy", {31'b0, in_ready}, 32'd1);
        chk("abort_ov", {31'b0, out_valid}, 32'd0);
        chk("abort_res", result, 32'h0);
        spur = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) spur++;
        end
        chk("abort_spur", spur, 32'd0);
        mul_run("mul_fresh", MUL | BBUS0, 32'h6, 32'h7, 32'd42);

        step();
        chk("end_ov", {31'b0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
